// File: rtl/sobel_window_gen.sv
// sobel_window_gen: raster-scan 3x3 window generator feeding sobel_calc; define SOBEL_WIN_SOF_EN to add the sof_i resync input
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
`ifdef SOBEL_WIN_SOF_EN
  input  logic              sof_i,
`endif
  input  logic [DATA_W-1:0] pixel_i,
  input  logic              valid_i,
  output logic [DATA_W-1:0] d0_o,
  output logic [DATA_W-1:0] d1_o,
  output logic [DATA_W-1:0] d2_o,
  output logic [DATA_W-1:0] d3_o,
  output logic [DATA_W-1:0] d4_o,
  output logic [DATA_W-1:0] d5_o,
  output logic [DATA_W-1:0] d6_o,
  output logic [DATA_W-1:0] d7_o,
  output logic [DATA_W-1:0] d8_o,
  output logic              done_o,
  output logic              frame_done_o
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT - 1);
  logic [CW-1:0] col, c, col_n;
  logic [RW-1:0] row, r, row_n;
  logic sof, c_last, r_last, win;
  logic [DATA_W-1:0] lb0 [IMG_WIDTH];
  logic [DATA_W-1:0] lb1 [IMG_WIDTH];
  // position of the pixel being accepted (sof forces 0,0) and the advanced counters
  always_comb begin
`ifdef SOBEL_WIN_SOF_EN
    sof = valid_i & sof_i;
`else
    sof = 1'b0;
`endif
    c = sof ? '0 : col;
    r = sof ? '0 : row;
    c_last = c == C_LAST;
    r_last = r == R_LAST;
    col_n = c_last ? '0 : c + CW'(1);
    row_n = c_last ? (r_last ? '0 : r + RW'(1)) : r;
    win = r >= RW'(2) && c >= CW'(2);
  end
  // line buffers shift a column down one row per accept; read-before-write, not reset
  always_ff @(posedge clk) begin
    if (valid_i) begin
      lb0[c] <= lb1[c];
      lb1[c] <= pixel_i;
    end
  end
  // counters, 3x3 window shift and the window/frame strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
      {d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o, d7_o, d8_o} <= '0;
      done_o <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      done_o <= valid_i & win;
      frame_done_o <= valid_i & c_last & r_last;
      if (valid_i) begin
        col <= col_n;
        row <= row_n;
        {d0_o, d1_o, d2_o} <= {d1_o, d2_o, lb0[c]};
        {d3_o, d4_o, d5_o} <= {d4_o, d5_o, lb1[c]};
        {d6_o, d7_o, d8_o} <= {d7_o, d8_o, pixel_i};
      end
    end
  end
endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
Raster-scan 3x3 window generator that sits directly upstream of sobel_calc. It accepts one grayscale pixel per valid cycle. Two on-chip line buffers plus a 3x3 shift-register window present d0..d8 to sobel_calc, with a done_o strobe each time a complete in-image window forms. No border padding is applied, so each frame yields (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows.

Parameters:
IMG_WIDTH, 640, pixels per line (>=3); line-buffer depth.
IMG_HEIGHT, 480, lines per frame (>=3).
DATA_W, 8, pixel width.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
pixel_i  input  DATA_W  incoming pixel, raster order (left->right, top->bottom).
valid_i  input  1  pixel_i is valid this cycle; a pixel is accepted on every clk edge with valid_i=1 (no backpressure).
d0_o..d8_o  output  DATA_W each  3x3 window; feeds sobel_calc d0_i..d8_i.
done_o  output  1  window valid strobe; feeds sobel_calc done_i.
frame_done_o  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset (async, asserts immediately): col=0, row=0, d0_o..d8_o=0, done_o=0, frame_done_o=0. Line-buffer RAM is not reset (don't-care: rows 0-1 never produce windows).
- Counters: col is 0..IMG_WIDTH-1 and row is 0..IMG_HEIGHT-1, both $clog2-sized. On accept, col++. At col=IMG_WIDTH-1, col->0 and row++. At row=IMG_HEIGHT-1 with col=IMG_WIDTH-1, both wrap to 0, which starts the next frame with no idle cycle needed.
- Line buffers lb0 (row r-2) and lb1 (row r-1), depth IMG_WIDTH, indexed by col. On accept at col c: read lb0[c] and lb1[c]; write lb0[c]<=lb1[c] and lb1[c]<=pixel_i in the same cycle (read-before-write).
- Window shift on accept: the right column loads d2<=lb0[c], d5<=lb1[c], d8<=pixel_i; the middle column takes the old right column (d1<=d2, d4<=d5, d7<=d8); the left column takes the old middle column (d0<=d1, d3<=d4, d6<=d7).
- Window mapping: d0 = pixel(r-2,c-2), d2 = pixel(r-2,c), d6 = pixel(r,c-2), d8 = pixel(r,c), i.e. d0..d2 is the oldest row and d0,d3,d6 is the leftmost column. This matches the sobel_calc gx/gy equations.
- done_o: registered. On an accept it is set to (row>=2 && col>=2), using the counter values before increment. Any cycle with valid_i=0 clears it. It is therefore high exactly one cycle after the accepting edge, aligned with the d*_o it qualifies.
- Stall (valid_i=0): counters, window registers and line buffers all hold. done_o=0.
- Line wrap: the window at col 0/1 of a new line holds stale left columns, but done_o stays low because col<2, so these windows never leak.
- frame_done_o: registered pulse, 1 on the cycle after the accept at (IMG_HEIGHT-1, IMG_WIDTH-1), 0 otherwise. When that accept also completes a window, it coincides with the final done_o.
- Reset mid-frame: all state returns to the reset values immediately. The next accepted pixel is treated as (0,0).

Optional Feature:
SOBEL_WIN_SOF_EN
- Defined: adds input port sof_i (1 bit), qualified by valid_i. An accept with sof_i=1 is treated as pixel (0,0): counters are forced so the pixel is processed at col=0,row=0 and post-increment values are col=1,row=0. done_o=0 for that pixel, and frame_done_o is not generated for the truncated frame. This resynchronises the block after dropped pixels.
- Not defined: no sof_i port. Frame position is derived solely from the pixel count.

Test Plan:
1. IMG_WIDTH=4, IMG_HEIGHT=4; send pixels 1..16 back-to-back after reset -> done_o high exactly 4 times (after pixels 11,12,15,16). The first window is d0..d8 = 1,2,3,5,6,7,9,10,11; fed to sobel_calc it gives |gx|+|gy| = 8+32 = 40.
2. Same stream; check the second window -> d0..d8 = 2,3,4,6,7,8,10,11,12. No done_o after pixels 13 and 14 (col<2). frame_done_o pulses once, coincident with the last done_o.
3. Same stream with valid_i=0 for 3 cycles between pixels 11 and 12 -> done_o drops to 0 during the gap, d*_o hold 1..11 values, the pixel-12 window is unchanged from test 2.
4. Two frames back-to-back (pixels 1..16, then 101..116) -> the second frame's first window is 101,102,103,105,106,107,109,110,111. Exactly 8 done_o pulses and 2 frame_done_o pulses in total.
5. Assert rst asynchronously (mid-cycle) after pixel 7 -> outputs are 0 immediately. Then send 1..16 -> results identical to test 1.
6. SOBEL_WIN_SOF_EN defined: send 1..6, then 1..16 with sof_i=1 on the first pixel -> windows identical to test 1, and frame_done_o pulses only once.
